// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, instruction fields and FSM states for the course CPU
// Contents: ALU/opcode codes, instruction field positions, sequencer state enum,
//           opcode legality helper.
package cpu_pkg;

  localparam int XLEN = 16;

  // Opcodes are identical to the ALU function codes, so decode is a pass-through.
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b0000;

  // Instruction field positions.
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int IMM_SEL = 8;
  localparam int RS_HI   = 7;
  localparam int RS_LO   = 5;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  function automatic logic is_legal(input logic [3:0] opc);
    case (opc)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_legal = 1'b1;
      default:                                       is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - instruction handshake, ALU and writeback bus of the execute sequencer
// Signals: instr_valid/instr/instr_ready (instruction handshake), op_a/op_b/alu_func/alu_out
//          (ALU bus), retire/wb_addr/wb_data (writeback report), illegal (undefined opcode pulse).
// Modports: master = upstream + ALU side, slave = sequencer side.
interface exec_sequencer_if;
  import cpu_pkg::*;

  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic            instr_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      alu_func;
  logic [XLEN-1:0] alu_out;
  logic            retire;
  logic [2:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, op_a, op_b, alu_func, retire, wb_addr, wb_data, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, op_a, op_b, alu_func, retire, wb_addr, wb_data, illegal
  );

endinterface

// File: rtl/exec_regfile.sv
// rtl/exec_regfile.sv - 8x16 register file, two read ports, debug read port, one write port
// Ports: clk, rst_n (async clear of all entries), ra_addr/ra_data and rb_addr/rb_data
//        (combinational reads), dbg_addr/dbg_data (combinational debug read),
//        we/waddr/wdata (synchronous write).
module exec_regfile
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [2:0]      rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic [2:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - four-cycle execute sequencer in front of an external combinational ALU
// Ports: clk, rst_n (async, active-low), bus (exec_sequencer_if.slave: instruction handshake,
//        ALU operands/function/result, retire/writeback report, illegal pulse),
//        busy (not IDLE), flag_z/flag_n (status flags), dbg_addr/dbg_data (register peek).
// Build option: EXEC_FLAGS_EN adds Z/N flag registers updated on writeback;
//               without it flag_z/flag_n are constant 0.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_sequencer_if.slave bus,
  output logic            busy,
  output logic            flag_z,
  output logic            flag_n,
  input  logic [2:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_e          state;
  logic [XLEN-1:0] ir;

  logic [3:0]      opc;
  logic [2:0]      rd;
  logic [2:0]      rs;
  logic            imm_sel;
  logic [7:0]      imm8;

  logic [XLEN-1:0] ra_data;
  logic [XLEN-1:0] rb_data;
  logic [XLEN-1:0] op_b_next;

  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic [3:0]      func_q;
  logic            retire_q;
  logic            illegal_q;
  logic [2:0]      wb_addr_q;
  logic [XLEN-1:0] wb_data_q;

  // Fields are decoded from the latched copy; the live bus.instr is only
  // looked at on the accept edge.
  assign opc     = ir[OPC_HI:OPC_LO];
  assign rd      = ir[RD_HI:RD_LO];
  assign rs      = ir[RS_HI:RS_LO];
  assign imm_sel = ir[IMM_SEL];
  assign imm8    = ir[IMM_HI:IMM_LO];

  assign op_b_next = imm_sel ? {8'h00, imm8} : rb_data;

  // Writeback lands on the edge that leaves WB, so the next DECODE already
  // sees the new value and no forwarding path is needed.
  exec_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (rd),
    .ra_data  (ra_data),
    .rb_addr  (rs),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (state == WB),
    .waddr    (wb_addr_q),
    .wdata    (wb_data_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir        <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      func_q    <= OP_NOP;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_legal(opc)) begin
            op_a_q <= ra_data;
            op_b_q <= op_b_next;
            func_q <= opc;
            state  <= EXEC;
          end else begin
            // ALU outputs stay as they were; only the pulse is raised.
            illegal_q <= 1'b1;
            state     <= IDLE;
          end
        end
        EXEC: begin
          wb_data_q <= bus.alu_out;
          wb_addr_q <= rd;
          retire_q  <= 1'b1;
          state     <= WB;
        end
        WB: begin
          func_q <= OP_NOP;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXEC_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (state == WB) begin
      flag_z_q <= (wb_data_q == '0);
      flag_n_q <= wb_data_q[XLEN-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  assign bus.instr_ready = (state == IDLE);
  assign busy            = (state != IDLE);
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.alu_func    = func_q;
  assign bus.retire      = retire_q;
  assign bus.illegal     = illegal_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer with a behavioural ALU and reference model
module tb_exec_sequencer;

`ifdef EXEC_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        flag_z;
  logic        flag_n;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  exec_sequencer_if bus ();

  exec_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    case (bus.alu_func)
      4'b0001: bus.alu_out = bus.op_b;
      4'b0010: bus.alu_out = bus.op_a + bus.op_b;
      4'b0100: bus.alu_out = bus.op_a - bus.op_b;
      4'b0110: bus.alu_out = bus.op_a & bus.op_b;
      4'b1000: bus.alu_out = bus.op_a | bus.op_b;
      4'b1010: bus.alu_out = bus.op_a ^ bus.op_b;
      default: bus.alu_out = 16'h0000;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents and flags.
  logic [15:0] m_reg [8];
  bit          m_z;
  bit          m_n;

  typedef struct {
    logic [15:0] instr;
    bit          ill;
    logic [2:0]  rd;
    logic [15:0] data;
    bit          z;
    bit          n;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_z = 1'b0;
    m_n = 1'b0;
  endtask

  function automatic void model_exec(input logic [15:0] ins, output bit legal,
                                     output logic [15:0] a, output logic [15:0] b,
                                     output logic [15:0] res);
    logic [3:0] o;
    o     = ins[15:12];
    a     = m_reg[ins[11:9]];
    b     = ins[8] ? {8'h00, ins[7:0]} : m_reg[ins[7:5]];
    legal = 1'b1;
    res   = 16'h0000;
    case (o)
      4'h1: res = b;
      4'h2: res = 16'((32'(a) + 32'(b)) % 32'h10000);
      4'h4: res = 16'((32'(a) + 32'h10000 - 32'(b)) % 32'h10000);
      4'h6: res = a & b;
      4'h8: res = a | b;
      4'hA: res = a ^ b;
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int waited = 0;
    while (!bus.instr_ready && waited < 12) begin
      @(posedge clk); #1;
      waited++;
    end
    check(name, bus.instr_ready, 1);
  endtask

  // Issues one instruction and checks every cycle until it finishes.
  // Called and returns #1 after a rising edge.
  task automatic run_instr(input logic [15:0] ins, output bit got_ill, output logic [2:0] got_rd,
                           output logic [15:0] got_data, output bit got_z, output bit got_n);
    bit          legal;
    logic [15:0] a, b, res, r;
    logic [2:0]  rd;
    logic [15:0] pre_a, pre_b;
    logic [3:0]  pre_f;
    rd       = ins[11:9];
    dbg_addr = rd;
    got_rd   = rd;
    got_data = 16'h0000;
    wait_ready("ready_wait");
    model_exec(ins, legal, a, b, res);
    pre_a = bus.op_a;
    pre_b = bus.op_b;
    pre_f = bus.alu_func;
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    r = 16'($urandom);
    bus.instr = r;
    check("decode_busy", busy, 1);
    check("decode_ready", bus.instr_ready, 0);
    @(posedge clk); #1;
    got_ill = bus.illegal;
    if (!legal) begin
      check("ill_pulse", bus.illegal, 1);
      check("ill_ready", bus.instr_ready, 1);
      check("ill_op_a_kept", bus.op_a, pre_a);
      check("ill_op_b_kept", bus.op_b, pre_b);
      check("ill_func_kept", bus.alu_func, pre_f);
      @(posedge clk); #1;
      check("ill_pulse_end", bus.illegal, 0);
      check("ill_no_retire", bus.retire, 0);
      check("ill_reg_kept", dbg_data, m_reg[rd]);
    end else begin
      check("exec_no_ill", bus.illegal, 0);
      check("exec_op_a", bus.op_a, a);
      check("exec_op_b", bus.op_b, b);
      check("exec_func", bus.alu_func, ins[15:12]);
      @(posedge clk); #1;
      check("wb_retire", bus.retire, 1);
      check("wb_addr", bus.wb_addr, rd);
      check("wb_data", bus.wb_data, res);
      check("wb_dbg_old", dbg_data, m_reg[rd]);
      got_data = bus.wb_data;
      @(posedge clk); #1;
      check("post_retire", bus.retire, 0);
      check("post_func_clr", bus.alu_func, 0);
      check("post_ready", bus.instr_ready, 1);
      check("post_dbg_new", dbg_data, res);
      m_reg[rd] = res;
      if (FLAGS_EN) begin
        m_z = (res == 16'h0000);
        m_n = res[15];
      end
    end
    check("flag_z", flag_z, m_z);
    check("flag_n", flag_n, m_n);
    got_z = flag_z;
    got_n = flag_n;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_op_a"}, bus.op_a, 0);
    check({tag, "_op_b"}, bus.op_b, 0);
    check({tag, "_func"}, bus.alu_func, 0);
    check({tag, "_retire"}, bus.retire, 0);
    check({tag, "_illegal"}, bus.illegal, 0);
    check({tag, "_wb_addr"}, bus.wb_addr, 0);
    check({tag, "_wb_data"}, bus.wb_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, bus.instr_ready, 1);
    check({tag, "_flag_z"}, flag_z, 0);
    check({tag, "_flag_n"}, flag_n, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check({tag, "_reg"}, dbg_data, 0);
    end
  endtask

  // Asserts reset `stage` cycles after the handshake of `ins`, mid-cycle.
  task automatic reset_during(input logic [15:0] ins, input int stage, input bit pulse_before);
    wait_ready("rst_ready_wait");
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int i = 0; i < stage; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_pulse", bus.retire | bus.illegal, pulse_before);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(posedge clk); #1;
    check("rst_hold_retire", bus.retire, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  logic [3:0] legal_ops [6];

  initial begin
    bit          gi, gz, gn;
    logic [2:0]  grd;
    logic [15:0] gd;
    logic [15:0] q [4];
    logic [15:0] exp_wb [4];
    logic [15:0] r;
    logic [3:0]  o;
    int          hs [$];
    logic [15:0] rq [$];
    int          cyc, k, bad;
    bit          rdy, bsy, legal;
    logic [15:0] a, b, res;

    legal_ops = '{4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA};

    //            instr     ill   rd    data      z     n
    tbl[0]  = '{16'h13A5, 1'b0, 3'd1, 16'h00A5, 1'b0, 1'b0};
    tbl[1]  = '{16'h155B, 1'b0, 3'd2, 16'h005B, 1'b0, 1'b0};
    tbl[2]  = '{16'h2240, 1'b0, 3'd1, 16'h0100, 1'b0, 1'b0};
    tbl[3]  = '{16'h4220, 1'b0, 3'd1, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{16'h4701, 1'b0, 3'd3, 16'hFFFF, 1'b0, 1'b1};
    tbl[5]  = '{16'hF000, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{16'h650F, 1'b0, 3'd2, 16'h000B, 1'b0, 1'b0};
    tbl[7]  = '{16'hA460, 1'b0, 3'd2, 16'hFFF4, 1'b0, 1'b1};
    tbl[8]  = '{16'h8980, 1'b0, 3'd4, 16'h0080, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{16'h117E, 1'b0, 3'd0, 16'h007E, 1'b0, 1'b0};
    tbl[11] = '{16'h1FFF, 1'b0, 3'd7, 16'h00FF, 1'b0, 1'b0};
    tbl[12] = '{16'h3123, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{16'h1CE0, 1'b0, 3'd6, 16'h00FF, 1'b0, 1'b0};

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    dbg_addr        = 3'd0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].instr, gi, grd, gd, gz, gn);
      check("tbl_illegal", gi, tbl[i].ill);
      if (!tbl[i].ill) begin
        check("tbl_rd", grd, tbl[i].rd);
        check("tbl_data", gd, tbl[i].data);
      end
      check("tbl_z", gz, FLAGS_EN ? tbl[i].z : 1'b0);
      check("tbl_n", gn, FLAGS_EN ? tbl[i].n : 1'b0);
    end

    // Back-to-back with instr_valid held high, including RAW chains.
    r = 16'($urandom);
    q[0] = {8'h19, r[7:0]};
    q[1] = 16'h2880;
    q[2] = {8'h1B, r[15:8]};
    q[3] = 16'hAA80;
    for (int i = 0; i < 4; i++) begin
      model_exec(q[i], legal, a, b, res);
      exp_wb[i] = res;
      m_reg[q[i][11:9]] = res;
      if (FLAGS_EN) begin
        m_z = (res == 16'h0000);
        m_n = res[15];
      end
    end
    cyc = 0;
    k   = 0;
    bad = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = q[0];
    while (rq.size() < 4 && cyc < 40) begin
      rdy = bus.instr_ready;
      bsy = busy;
      if (bsy && rdy) bad++;
      if (!bsy && !rdy) bad++;
      @(posedge clk); #1;
      cyc++;
      if (rdy && bus.instr_valid) begin
        hs.push_back(cyc);
        k++;
        if (k < 4) bus.instr = q[k];
        else bus.instr_valid = 1'b0;
      end
      if (bus.retire) rq.push_back(bus.wb_data);
    end
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_handshakes", hs.size(), 4);
    check("b2b_retires", rq.size(), 4);
    check("b2b_ready_vs_busy", bad, 0);
    if (hs.size() == 4) begin
      for (int i = 1; i < 4; i++) check("b2b_spacing", hs[i] - hs[i-1], 4);
    end
    if (rq.size() == 4) begin
      for (int i = 0; i < 4; i++) check("b2b_wb_data", rq[i], exp_wb[i]);
    end
    dbg_addr = 3'd4; #1;
    check("b2b_r4", dbg_data, m_reg[4]);
    dbg_addr = 3'd5; #1;
    check("b2b_r5", dbg_data, m_reg[5]);
    check("b2b_flag_z", flag_z, m_z);
    check("b2b_flag_n", flag_n, m_n);
    @(posedge clk); #1;

    // Randomized instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 9) < 8) o = legal_ops[$urandom_range(0, 5)];
      else o = 4'($urandom);
      run_instr({o, r[11:0]}, gi, grd, gd, gz, gn);
    end

    // Reset in the middle of an ADD (EXEC), during an illegal pulse and during WB.
    reset_during(16'h2240, 1, 1'b0);
    run_instr(16'h13C3, gi, grd, gd, gz, gn);
    check("after_rst_data", gd, 16'h00C3);
    reset_during(16'hF000, 1, 1'b1);
    reset_during(16'h1B11, 2, 1'b1);
    run_instr(16'h1B11, gi, grd, gd, gz, gn);
    check("after_rst2_data", gd, 16'h0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
